i2c_arbiter: RTL and testbench

Two-port arbiter that shares a single i2c_master between two transaction controllers (e.g. an EEPROM reader and an EEPROM writer). It grants bus ownership round-robin, muxes the owner's control bundle onto the master, routes master handshakes back to the owner only, and holds ownership until the owner releases and the master goes idle. A no-activity watchdog revokes a stuck grant.

---
 rtl/i2c_arbiter.sv | 146 ++++++++++++++
 tb/tb_i2c_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master between two transaction controllers.
// The owner keeps the bus until it drops req and the master goes idle; a watchdog revokes a stuck grant.
module i2c_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       start0,
    input  logic       start1,
    input  logic [6:0] slave_addr0,
    input  logic [6:0] slave_addr1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [7:0] write_data0,
    input  logic [7:0] write_data1,
    input  logic [7:0] nbytes0,
    input  logic [7:0] nbytes1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] read_data0,
    output logic [7:0] read_data1,
    output logic       tx_data_req0,
    output logic       tx_data_req1,
    output logic       rx_data_ready0,
    output logic       rx_data_ready1,
    output logic       m_start,
    output logic       m_rw,
    output logic [6:0] m_slave_addr,
    output logic [7:0] m_write_data,
    output logic [7:0] m_nbytes,
    input  logic [7:0] m_read_data,
    input  logic       m_tx_data_req,
    input  logic       m_rx_data_ready,
    input  logic       m_busy,
    output logic       arb_busy,
    output logic       timeout_err,
    output logic       timeout_port
);
    // state | meaning
    // IDLE  | no owner; next request (or tie winner) is granted
    // OWN   | owner's control drives the master; watchdog counts idle cycles
    // DRAIN | grant dropped; waits for the master to finish (m_busy low)
    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        last_owner, last_owner_nxt;
    logic [15:0] idle_cnt, idle_cnt_nxt;
    logic        timeout_err_nxt, timeout_port_nxt;
    logic        req_owner, sel0, sel1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_owner   <= 1'b1;
            idle_cnt     <= 16'd0;
            timeout_err  <= 1'b0;
            timeout_port <= 1'b0;
        end else begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            last_owner   <= last_owner_nxt;
            idle_cnt     <= idle_cnt_nxt;
            timeout_err  <= timeout_err_nxt;
            timeout_port <= timeout_port_nxt;
        end
    end

    assign req_owner = owner ? req1 : req0;

    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        last_owner_nxt   = last_owner;
        idle_cnt_nxt     = idle_cnt;
        timeout_err_nxt  = 1'b0;
        timeout_port_nxt = timeout_port;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt    = OWN;
                    idle_cnt_nxt = 16'd0;
                    owner_nxt    = (req0 && req1) ? ~last_owner : req1;
                end
            end
            OWN: begin
                // A release wins over a simultaneous watchdog expiry.
                if (!req_owner) begin
                    state_nxt      = DRAIN;
                    last_owner_nxt = owner;
                end else if (m_tx_data_req || m_rx_data_ready) begin
                    idle_cnt_nxt = 16'd0;
                end else if (TIMEOUT_CYCLES != 16'd0 && idle_cnt == TIMEOUT_CYCLES - 16'd1) begin
                    state_nxt        = DRAIN;
                    last_owner_nxt   = owner;
                    timeout_err_nxt  = 1'b1;
                    timeout_port_nxt = owner;
                end else begin
                    idle_cnt_nxt = idle_cnt + 16'd1;
                end
            end
            DRAIN: begin
                if (!m_busy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Everything below decodes from flops, so reset clears it without a clock edge.
    assign sel0     = (state == OWN) && !owner;
    assign sel1     = (state == OWN) && owner;
    assign gnt0     = sel0;
    assign gnt1     = sel1;
    assign arb_busy = (state != IDLE);

    always_comb begin
        m_start      = 1'b0;
        m_rw         = 1'b0;
        m_slave_addr = 7'd0;
        m_write_data = 8'd0;
        m_nbytes     = 8'd0;
        if (sel0) begin
            m_start      = start0;
            m_rw         = rw0;
            m_slave_addr = slave_addr0;
            m_write_data = write_data0;
            m_nbytes     = nbytes0;
        end else if (sel1) begin
            m_start      = start1;
            m_rw         = rw1;
            m_slave_addr = slave_addr1;
            m_write_data = write_data1;
            m_nbytes     = nbytes1;
        end
    end

    assign read_data0     = sel0 ? m_read_data : 8'd0;
    assign read_data1     = sel1 ? m_read_data : 8'd0;
    assign tx_data_req0   = sel0 & m_tx_data_req;
    assign tx_data_req1   = sel1 & m_tx_data_req;
    assign rx_data_ready0 = sel0 & m_rx_data_ready;
    assign rx_data_ready1 = sel1 & m_rx_data_ready;
endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: reset, single owner, tie/round-robin, drain hold, watchdog, async reset.
module tb_i2c_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, start0, start1, rw0, rw1;
    logic [6:0] slave_addr0, slave_addr1;
    logic [7:0] write_data0, write_data1, nbytes0, nbytes1;
    logic       gnt0, gnt1;
    logic [7:0] read_data0, read_data1;
    logic       tx_data_req0, tx_data_req1, rx_data_ready0, rx_data_ready1;
    logic       m_start, m_rw;
    logic [6:0] m_slave_addr;
    logic [7:0] m_write_data, m_nbytes, m_read_data;
    logic       m_tx_data_req, m_rx_data_ready, m_busy;
    logic       arb_busy, timeout_err, timeout_port;

    int total = 0;
    int bad   = 0;

    i2c_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .start0(start0), .start1(start1),
        .slave_addr0(slave_addr0), .slave_addr1(slave_addr1),
        .rw0(rw0), .rw1(rw1),
        .write_data0(write_data0), .write_data1(write_data1),
        .nbytes0(nbytes0), .nbytes1(nbytes1),
        .gnt0(gnt0), .gnt1(gnt1),
        .read_data0(read_data0), .read_data1(read_data1),
        .tx_data_req0(tx_data_req0), .tx_data_req1(tx_data_req1),
        .rx_data_ready0(rx_data_ready0), .rx_data_ready1(rx_data_ready1),
        .m_start(m_start), .m_rw(m_rw), .m_slave_addr(m_slave_addr),
        .m_write_data(m_write_data), .m_nbytes(m_nbytes), .m_read_data(m_read_data),
        .m_tx_data_req(m_tx_data_req), .m_rx_data_ready(m_rx_data_ready), .m_busy(m_busy),
        .arb_busy(arb_busy), .timeout_err(timeout_err), .timeout_port(timeout_port)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0; start0 = 0; start1 = 0; rw0 = 0; rw1 = 0;
        slave_addr0 = 0; slave_addr1 = 0; write_data0 = 0; write_data1 = 0;
        nbytes0 = 0; nbytes1 = 0;
        m_read_data = 0; m_tx_data_req = 0; m_rx_data_ready = 0; m_busy = 0;
        #3;
        total++;
        if ({gnt0, gnt1, arb_busy, m_start, timeout_err, timeout_port} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {gnt0, gnt1, arb_busy, m_start, timeout_err, timeout_port});
        end
        total++;
        if ({m_slave_addr, m_nbytes, m_write_data, m_rw} !== 24'd0) begin
            bad++;
            $display("FAIL reset_m_bus got=%h want=0", {m_slave_addr, m_nbytes, m_write_data, m_rw});
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        req0 = 1; start0 = 1; slave_addr0 = 7'h50; nbytes0 = 8'd2; write_data0 = 8'hA5; rw0 = 0;
        #1;
        total++;
        if (gnt0 !== 1'b0 || m_start !== 1'b0) begin
            bad++;
            $display("FAIL single_pre_grant gnt0=%b m_start=%b want 0 0", gnt0, m_start);
        end
        tick();
        total++;
        if ({gnt0, gnt1, arb_busy} !== 3'b101) begin
            bad++;
            $display("FAIL single_grant got=%b want=101", {gnt0, gnt1, arb_busy});
        end
        total++;
        if (m_slave_addr !== 7'h50 || m_nbytes !== 8'd2 || m_write_data !== 8'hA5 || m_start !== 1'b1) begin
            bad++;
            $display("FAIL single_mux addr=%h nbytes=%0d wd=%h start=%b want 50 2 a5 1",
                     m_slave_addr, m_nbytes, m_write_data, m_start);
        end
        m_tx_data_req = 1;
        #1;
        total++;
        if (tx_data_req0 !== 1'b1 || tx_data_req1 !== 1'b0) begin
            bad++;
            $display("FAIL single_tx_route got=%b%b want=10", tx_data_req0, tx_data_req1);
        end
        m_tx_data_req = 0; m_read_data = 8'h3C; m_rx_data_ready = 1;
        #1;
        total++;
        if (read_data0 !== 8'h3C || read_data1 !== 8'h00 || rx_data_ready0 !== 1'b1 || rx_data_ready1 !== 1'b0) begin
            bad++;
            $display("FAIL single_rx_route rd0=%h rd1=%h rr0=%b rr1=%b want 3c 00 1 0",
                     read_data0, read_data1, rx_data_ready0, rx_data_ready1);
        end
        tick();
        m_rx_data_ready = 0; m_read_data = 0;
        req0 = 0; start0 = 0;
        tick();
        total++;
        if (gnt0 !== 1'b0 || arb_busy !== 1'b1 || m_slave_addr !== 7'd0) begin
            bad++;
            $display("FAIL single_drain gnt0=%b busy=%b addr=%h want 0 1 00", gnt0, arb_busy, m_slave_addr);
        end
        tick();
        total++;
        if (arb_busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle arb_busy=%b want 0", arb_busy);
        end
    endtask

    task automatic test_tie();
        reset = 1;
        #2;
        reset = 0;
        req0 = 1; req1 = 1;
        tick();
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL tie_first got=%b want=10", {gnt0, gnt1});
        end
        req0 = 0;
        tick();
        total++;
        if ({gnt0, gnt1} !== 2'b00) begin
            bad++;
            $display("FAIL tie_release_k got=%b want=00", {gnt0, gnt1});
        end
        tick();
        total++;
        if (gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL tie_release_k1 gnt1=%b want 0", gnt1);
        end
        tick();
        total++;
        if ({gnt0, gnt1} !== 2'b01) begin
            bad++;
            $display("FAIL tie_regrant got=%b want=01", {gnt0, gnt1});
        end
        req0 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({gnt0, gnt1} !== 2'b01) begin
                bad++;
                $display("FAIL tie_wait cyc=%0d got=%b want=01", i, {gnt0, gnt1});
            end
        end
        req1 = 0;
        tick();
        tick();
        tick();
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL tie_port0_back got=%b want=10", {gnt0, gnt1});
        end
        req0 = 0;
        tick();
        tick();
    endtask

    task automatic test_drain();
        req0 = 1; start0 = 1; start1 = 1;
        tick();
        req1 = 1; m_busy = 1;
        tick();
        req0 = 0;
        tick();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (gnt1 !== 1'b0 || m_start !== 1'b0 || arb_busy !== 1'b1) begin
                bad++;
                $display("FAIL drain_hold cyc=%0d gnt1=%b m_start=%b busy=%b want 0 0 1",
                         i, gnt1, m_start, arb_busy);
            end
            tick();
        end
        m_busy = 0;
        tick();
        total++;
        if (gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL drain_idle gnt1=%b want 0", gnt1);
        end
        tick();
        total++;
        if (gnt1 !== 1'b1 || m_start !== 1'b1) begin
            bad++;
            $display("FAIL drain_regrant gnt1=%b m_start=%b want 1 1", gnt1, m_start);
        end
        req1 = 0; start0 = 0; start1 = 0;
        tick();
        tick();
    endtask

    task automatic test_watchdog();
        req1 = 1;
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            total++;
            if (gnt1 !== 1'b1 || timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL wd_count cyc=%0d gnt1=%b err=%b want 1 0", i, gnt1, timeout_err);
            end
        end
        tick();
        total++;
        if ({gnt1, timeout_err, timeout_port, arb_busy} !== 4'b0111) begin
            bad++;
            $display("FAIL wd_expire got=%b want=0111", {gnt1, timeout_err, timeout_port, arb_busy});
        end
        tick();
        total++;
        if (timeout_err !== 1'b0 || timeout_port !== 1'b1) begin
            bad++;
            $display("FAIL wd_pulse err=%b port=%b want 0 1", timeout_err, timeout_port);
        end
        tick();
        total++;
        if (gnt1 !== 1'b1) begin
            bad++;
            $display("FAIL wd_regrant gnt1=%b want 1", gnt1);
        end
        for (int i = 0; i < 4; i++) tick();
        m_rx_data_ready = 1;
        #1;
        total++;
        if (rx_data_ready1 !== 1'b1 || rx_data_ready0 !== 1'b0) begin
            bad++;
            $display("FAIL wd_rx_route got=%b%b want=01", rx_data_ready0, rx_data_ready1);
        end
        tick();
        m_rx_data_ready = 0;
        req0 = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if (gnt1 !== 1'b1 || timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL wd_restart cyc=%0d gnt1=%b err=%b want 1 0", i, gnt1, timeout_err);
            end
        end
        tick();
        total++;
        if (gnt1 !== 1'b0 || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL wd_restart_expire gnt1=%b err=%b want 0 1", gnt1, timeout_err);
        end
        tick();
        tick();
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL wd_fair got=%b want=10", {gnt0, gnt1});
        end
        req0 = 0; req1 = 0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        req0 = 1; start0 = 1;
        tick();
        total++;
        if (m_start !== 1'b1 || gnt0 !== 1'b1) begin
            bad++;
            $display("FAIL ar_setup m_start=%b gnt0=%b want 1 1", m_start, gnt0);
        end
        #2;
        reset = 1;
        #1;
        total++;
        if ({m_start, gnt0, arb_busy, timeout_port} !== 4'b0000) begin
            bad++;
            $display("FAIL ar_immediate got=%b want=0000", {m_start, gnt0, arb_busy, timeout_port});
        end
        #1;
        reset = 0;
        req1 = 1;
        tick();
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL ar_tie got=%b want=10", {gnt0, gnt1});
        end
        req0 = 0; req1 = 0; start0 = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_drain();
        test_watchdog();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout bench did not complete in time");
        $fatal(1);
    end
endmodule
